// File: rtl/apb_priority_intc.sv
// -----------------------------------------------------------------------------
// apb_priority_intc
//
// Priority interrupt controller with an APB (zero-wait-state) register port.
// Each source has a programmable priority, enable and trigger mode (level or
// rising edge). Among the eligible sources, the one with the highest priority
// is presented to the processor. Ties go to the lowest index. The presentation
// is held stable until the processor pulses irq_serviced.
//
// Register map (word address):
//   0 .. NUM_SRC-1 : PRIO[i]   RW  [PRIO_W-1:0]
//   NUM_SRC        : ENABLE    RW  [NUM_SRC-1:0]
//   NUM_SRC+1      : MODE      RW  1 = edge, 0 = level
//   NUM_SRC+2      : PENDING   RO  writing 1 to a bit clears that edge-latched bit
//   NUM_SRC+3      : THRESHOLD RW  [PRIO_W-1:0]
//   NUM_SRC+4      : STATUS    RO  {bit8 busy, [ID_W-1:0] current id}
//
// Ports:
//   pclk, preset_n         clock (rising edge) and async active-low reset
//   psel/penable/pwrite    APB control; access phase = psel & penable
//   paddr, pwdata          APB word address and write data
//   prdata                 read data, registered at the access-phase edge
//   pready                 always 1
//   pslverr                high during an access phase to an unmapped address
//   irq_src                synchronous interrupt inputs, one per source
//   irq_valid/id/prio      presented interrupt
//   irq_serviced           one-cycle pulse: processor finished irq_id
// -----------------------------------------------------------------------------
module apb_priority_intc #(
  parameter  int NUM_SRC = 16,
  parameter  int PRIO_W  = 4,
  parameter  int ADDR_W  = 6,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [PRIO_W-1:0]  irq_prio,
  input  logic               irq_serviced
);

  localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(NUM_SRC);
  localparam logic [ADDR_W-1:0] A_MODE    = ADDR_W'(NUM_SRC + 1);
  localparam logic [ADDR_W-1:0] A_PENDING = ADDR_W'(NUM_SRC + 2);
  localparam logic [ADDR_W-1:0] A_THRESH  = ADDR_W'(NUM_SRC + 3);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(NUM_SRC + 4);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SERVE} state_t;

  state_t              state, state_nxt;

  logic [PRIO_W-1:0]   prio [NUM_SRC];
  logic [NUM_SRC-1:0]  enable;
  logic [NUM_SRC-1:0]  mode;
  logic [PRIO_W-1:0]   threshold;

  logic [NUM_SRC-1:0]  pend_edge;   // latched rising edges (edge-mode sources)
  logic [NUM_SRC-1:0]  src_q;       // previous-cycle sample of irq_src
  logic                edge_armed;  // low only until the first edge after reset
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  clr;
  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  eligible;

  logic                access, wr_en, rd_en, unmapped;
  logic                any_elig, load, svc;
  logic [ID_W-1:0]     win_id;
  logic [PRIO_W-1:0]   win_prio;
  logic [31:0]         rdata_nxt;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  assign access   = psel & penable;
  assign wr_en    = access & pwrite;
  assign rd_en    = access & ~pwrite;
  assign unmapped = paddr > A_STATUS;
  assign pready   = 1'b1;
  assign pslverr  = access & unmapped;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  // NOTE: the priority array is software-visible and must read 0 after reset,
  // so it is built from resettable flops rather than left as an unreset memory.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
      enable    <= '0;
      mode      <= '0;
      threshold <= '0;
    end else if (wr_en) begin
      // NOTE: state is updated with non-blocking assignments so every process
      // sampling at this edge (arbiter, FSM) sees the pre-write values.
      if (paddr < A_ENABLE) begin
        prio[paddr[ID_W-1:0]] <= pwdata[PRIO_W-1:0];
      end else begin
        case (paddr)
          A_ENABLE: enable    <= pwdata[NUM_SRC-1:0];
          A_MODE:   mode      <= pwdata[NUM_SRC-1:0];
          A_THRESH: threshold <= pwdata[PRIO_W-1:0];
          default:  ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending logic
  // ---------------------------------------------------------------------------
  // A source already high when reset is released is not treated as an edge.
  assign rise = mode & irq_src & ~src_q & {NUM_SRC{edge_armed}};
  assign svc  = (state == S_SERVE) & irq_serviced;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    clr = '0;
    if (wr_en && paddr == A_PENDING) clr = pwdata[NUM_SRC-1:0];
    if (svc) clr[irq_id] = 1'b1;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pend_edge  <= '0;
      src_q      <= '0;
      edge_armed <= 1'b0;
    end else begin
      // Set has priority over clear: a new edge in the same cycle survives.
      pend_edge  <= (pend_edge & ~clr) | rise;
      src_q      <= irq_src;
      edge_armed <= 1'b1;
    end
  end

  // Level sources are not latched: they report the live input.
  assign pending = (mode & pend_edge) | (~mode & irq_src);

  // ---------------------------------------------------------------------------
  // Arbiter: highest priority wins; strict '>' keeps the lowest index on ties.
  // ---------------------------------------------------------------------------
  always_comb begin
    eligible = '0;
    any_elig = 1'b0;
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] & enable[i] & (prio[i] != '0) & (prio[i] > threshold);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!any_elig || prio[i] > win_prio)) begin
        any_elig = 1'b1;
        win_id   = ID_W'(i);
        win_prio = prio[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Presentation FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE:  if (any_elig) state_nxt = S_ARB;
      S_ARB: begin
        // The source seen in IDLE may have gone away; re-arbitrate here.
        if (any_elig) begin
          load      = 1'b1;
          state_nxt = S_SERVE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SERVE: if (irq_serviced) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded from the state flop so an asynchronous reset drops it at once.
  assign irq_valid = (state == S_SERVE);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      irq_id   <= '0;
      irq_prio <= '0;
    end else if (load) begin
      irq_id   <= win_id;
      irq_prio <= win_prio;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_nxt = '0;
    if (paddr < A_ENABLE) begin
      rdata_nxt[PRIO_W-1:0] = prio[paddr[ID_W-1:0]];
    end else begin
      case (paddr)
        A_ENABLE:  rdata_nxt[NUM_SRC-1:0] = enable;
        A_MODE:    rdata_nxt[NUM_SRC-1:0] = mode;
        A_PENDING: rdata_nxt[NUM_SRC-1:0] = pending;
        A_THRESH:  rdata_nxt[PRIO_W-1:0]  = threshold;
        A_STATUS: begin
          rdata_nxt[8]        = irq_valid;
          rdata_nxt[ID_W-1:0] = irq_id;
        end
        default:   rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)  prdata <= '0;
    else if (rd_en) prdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_apb_priority_intc.sv
// -----------------------------------------------------------------------------
// tb_apb_priority_intc
//
// Self-checking bench for apb_priority_intc (NUM_SRC=8, PRIO_W=3, ADDR_W=4).
// A behavioural model derives the expected register contents, the pending
// set and the presented interrupt from the controller's rules: eligibility
// test, max-priority / lowest-index selection, and presentation two edges
// after an eligible source is noticed while free. Directed scenarios are
// followed by a randomized phase. Outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_apb_priority_intc;

  localparam int N  = 8;
  localparam int PW = 3;
  localparam int AW = 4;

  logic          pclk;
  logic          preset_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [N-1:0]  irq_src;
  logic          irq_valid;
  logic [2:0]    irq_id;
  logic [PW-1:0] irq_prio;
  logic          irq_serviced;

  int n_checks = 0;
  int n_fail   = 0;

  apb_priority_intc #(.NUM_SRC(N), .PRIO_W(PW), .ADDR_W(AW)) dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .irq_src      (irq_src),
    .irq_valid    (irq_valid),
    .irq_id       (irq_id),
    .irq_prio     (irq_prio),
    .irq_serviced (irq_serviced)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [PW-1:0] m_prio [N];
  logic [N-1:0]  m_en, m_mode, m_edge, m_prev;
  logic [PW-1:0] m_thr;
  logic          m_armed;
  logic          m_valid;     // an interrupt is being presented
  logic          m_look;      // a free cycle has noticed an eligible source
  logic [2:0]    m_id;
  logic [PW-1:0] m_pr;
  logic [31:0]   m_rdata;

  function automatic logic [N-1:0] pend_now();
    return (m_mode & m_edge) | (~m_mode & irq_src);
  endfunction

  function automatic logic [N-1:0] elig_now();
    logic [N-1:0] p, e;
    p = pend_now();
    e = '0;
    for (int i = 0; i < N; i++)
      e[i] = p[i] && m_en[i] && (m_prio[i] != 0) && (m_prio[i] > m_thr);
    return e;
  endfunction

  // Highest priority among eligible sources, -1 when none.
  function automatic int top_prio();
    logic [N-1:0] e;
    int best;
    e = elig_now();
    best = -1;
    for (int i = 0; i < N; i++)
      if (e[i] && int'(m_prio[i]) > best) best = int'(m_prio[i]);
    return best;
  endfunction

  // Lowest eligible index carrying priority p.
  function automatic int first_with(int p);
    logic [N-1:0] e;
    e = elig_now();
    for (int i = 0; i < N; i++)
      if (e[i] && int'(m_prio[i]) == p) return i;
    return 0;
  endfunction

  function automatic logic [31:0] read_val(logic [AW-1:0] a);
    logic [31:0] v;
    v = '0;
    if (a < 4'(N)) v = 32'(m_prio[a[2:0]]);
    else begin
      case (int'(a))
        N:     v = 32'(m_en);
        N + 1: v = 32'(m_mode);
        N + 2: v = 32'(pend_now());
        N + 3: v = 32'(m_thr);
        N + 4: v = (m_valid ? 32'h100 : 32'h0) | 32'(m_id);
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [N-1:0] clr_mask();
    logic [N-1:0] c;
    c = '0;
    if (psel && penable && pwrite && int'(paddr) == N + 2) c = pwdata[N-1:0];
    if (m_valid && irq_serviced) c[m_id] = 1'b1;
    return c;
  endfunction

  function automatic logic [N-1:0] rise_mask();
    return m_armed ? (m_mode & irq_src & ~m_prev) : '0;
  endfunction

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < N; i++) m_prio[i] <= '0;
      m_en <= '0; m_mode <= '0; m_edge <= '0; m_prev <= '0; m_thr <= '0;
      m_armed <= 1'b0; m_valid <= 1'b0; m_look <= 1'b0;
      m_id <= '0; m_pr <= '0; m_rdata <= '0;
    end else begin
      if (psel && penable && pwrite) begin
        if (paddr < 4'(N))           m_prio[paddr[2:0]] <= pwdata[PW-1:0];
        else if (int'(paddr) == N)     m_en   <= pwdata[N-1:0];
        else if (int'(paddr) == N + 1) m_mode <= pwdata[N-1:0];
        else if (int'(paddr) == N + 3) m_thr  <= pwdata[PW-1:0];
      end
      if (psel && penable && !pwrite) m_rdata <= read_val(paddr);
      m_edge  <= (m_edge & ~clr_mask()) | rise_mask();
      m_prev  <= irq_src;
      m_armed <= 1'b1;
      if (m_valid) begin
        if (irq_serviced) m_valid <= 1'b0;
      end else if (m_look) begin
        m_look <= 1'b0;
        if (top_prio() >= 0) begin
          m_valid <= 1'b1;
          m_id    <= 3'(first_with(top_prio()));
          m_pr    <= PW'(top_prio());
        end
      end else if (top_prio() >= 0) begin
        m_look <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
    check("irq_valid", 32'(irq_valid), 32'(m_valid));
    check("irq_id",    32'(irq_id),    32'(m_id));
    check("irq_prio",  32'(irq_prio),  32'(m_pr));
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    #1 check("pslverr_setup", 32'(pslverr), 32'h0);
    tick();
    penable = 1'b1;
    #1 check("pslverr_wr", 32'(pslverr), 32'(int'(a) > N + 4));
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    #1 check("pslverr_rd", 32'(pslverr), 32'(int'(a) > N + 4));
    check("pready", 32'(pready), 32'h1);
    tick();
    check("prdata", prdata, m_rdata);
    d = prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_all(input bit expect_zero);
    logic [31:0] d;
    for (int a = 0; a <= N + 4; a++) begin
      apb_read(AW'(a), d);
      if (expect_zero) check("reg_after_reset", d, 32'h0);
    end
  endtask

  task automatic do_reset();
    preset_n = 1'b0; irq_src = '0; irq_serviced = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    preset_n = 1'b1;
    tick();
  endtask

  task automatic service();
    irq_serviced = 1'b1;
    tick();
    irq_serviced = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0]   d;
    logic [AW-1:0] a;

    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_src = '0; irq_serviced = 1'b0;
    #1;
    check("rst_irq_valid", 32'(irq_valid), 32'h0);
    check("rst_irq_id",    32'(irq_id),    32'h0);
    check("rst_irq_prio",  32'(irq_prio),  32'h0);
    check("rst_prdata",    prdata,         32'h0);
    check("rst_pslverr",   32'(pslverr),   32'h0);
    @(negedge pclk);
    preset_n = 1'b1;
    tick();

    // Two level sources, different priorities; then fall back to the other.
    apb_write(4'd2, 32'd5);
    apb_write(4'd6, 32'd3);
    apb_write(4'd8, 32'h44);
    irq_src = 8'h44;
    tick();
    check("lat_not_yet", 32'(irq_valid), 32'h0);
    tick();
    check("p1_valid", 32'(irq_valid), 32'h1);
    check("p1_id",    32'(irq_id),    32'd2);
    check("p1_prio",  32'(irq_prio),  32'd5);
    irq_src = 8'h40;
    service();
    check("p1_dropped", 32'(irq_valid), 32'h0);
    tick();
    tick();
    check("p2_id",   32'(irq_id),   32'd6);
    check("p2_prio", 32'(irq_prio), 32'd3);
    irq_src = 8'h00;
    service();

    // Equal priorities: lowest index; then threshold masks both.
    do_reset();
    apb_write(4'd1, 32'd4);
    apb_write(4'd4, 32'd4);
    apb_write(4'd8, 32'h12);
    irq_src = 8'h12;
    tick();
    tick();
    check("tie_valid", 32'(irq_valid), 32'h1);
    check("tie_id",    32'(irq_id),    32'd1);
    irq_src = 8'h00;
    service();
    apb_write(4'd11, 32'd4);
    irq_src = 8'h12;
    repeat (6) tick();
    check("thresh_masks", 32'(irq_valid), 32'h0);

    // Edge source captured while disabled, presented once enabled.
    do_reset();
    apb_write(4'd3, 32'd2);
    apb_write(4'd9, 32'h08);
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    tick();
    apb_read(4'd10, d);
    check("edge_pending", d, 32'h08);
    apb_write(4'd8, 32'h08);
    tick();
    tick();
    check("edge_valid", 32'(irq_valid), 32'h1);
    check("edge_id",    32'(irq_id),    32'd3);
    service();
    apb_read(4'd10, d);
    check("edge_cleared", d, 32'h00);

    // Presentation stays stable during SERVE despite writes / source drop.
    do_reset();
    apb_write(4'd2, 32'd5);
    apb_write(4'd8, 32'h04);
    irq_src = 8'h04;
    tick();
    tick();
    apb_write(4'd2, 32'd0);
    irq_src = 8'h00;
    repeat (3) tick();
    check("hold_valid", 32'(irq_valid), 32'h1);
    check("hold_id",    32'(irq_id),    32'd2);
    check("hold_prio",  32'(irq_prio),  32'd5);
    service();
    check("hold_released", 32'(irq_valid), 32'h0);

    // Unmapped address: read returns 0 with error, write has no effect.
    apb_read(4'd8, d);
    check("pre_unmapped_rd", d, 32'h04);
    apb_read(4'd15, d);
    check("unmapped_rdata", d, 32'h0);
    apb_write(4'd15, 32'hFFFF_FFFF);
    apb_write(4'd12, 32'hFFFF_FFFF);
    read_all(1'b0);
    apb_read(4'd8, d);
    check("unmapped_no_effect", d, 32'h04);

    // Asynchronous reset between edges during SERVE.
    do_reset();
    apb_write(4'd5, 32'd6);
    apb_write(4'd8, 32'h20);
    apb_write(4'd11, 32'd1);
    irq_src = 8'h20;
    tick();
    tick();
    check("serve_before_rst", 32'(irq_valid), 32'h1);
    #2 preset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(irq_valid), 32'h0);
    check("async_rst_id",    32'(irq_id),    32'h0);
    tick();
    irq_src  = 8'h00;
    preset_n = 1'b1;
    tick();
    read_all(1'b1);

    // Randomized traffic checked against the model every cycle.
    do_reset();
    for (int i = 0; i < N; i++) apb_write(AW'(i), 32'($urandom_range(0, 7)));
    apb_write(4'd8, 32'hFF);
    apb_write(4'd9, 32'($urandom));
    for (int it = 0; it < 500; it++) begin
      case ($urandom_range(0, 7))
        0, 1: begin irq_src = 8'($urandom); tick(); end
        2:    service();
        3: begin
          a = AW'($urandom_range(0, 15));
          d = $urandom;
          if (int'(a) == N + 3) d = 32'($urandom_range(0, 2));
          apb_write(a, d);
        end
        4: begin
          a = AW'($urandom_range(0, 15));
          apb_read(a, d);
        end
        5: begin irq_src = irq_src ^ (8'h01 << $urandom_range(0, 7)); tick(); end
        default: tick();
      endcase
    end
    irq_serviced = 1'b0;
    read_all(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_priority_intc.md
APB_PRIORITY_INTC -- requirements
Module: apb_priority_intc

Interface
REQ-001 SHALL have parameter NUM_SRC, default 16, number of interrupt sources (2..32).
REQ-002 SHALL have parameter PRIO_W, default 4, width of each priority field.
REQ-003 SHALL have parameter ADDR_W, default 6, APB word-address width; SHALL satisfy 2^ADDR_W >= NUM_SRC+5.
REQ-004 SHALL derive localparam ID_W = $clog2(NUM_SRC).
REQ-005 SHALL have ports as below; one clock; reset is asynchronous and active-low.
REQ-006 pclk  input  1  sole clock, rising edge.
REQ-007 preset_n  input  1  asynchronous active-low reset.
REQ-008 psel, penable, pwrite  input  1 each  APB control.
REQ-009 paddr  input  ADDR_W  APB word address.
REQ-010 pwdata  input  32  APB write data.
REQ-011 prdata  output  32  APB read data, registered.
REQ-012 pready  output  1  constant 1 (zero wait state).
REQ-013 pslverr  output  1  error on unmapped address, valid with pready.
REQ-014 irq_src  input  NUM_SRC  synchronous interrupt inputs, one per source.
REQ-015 irq_valid  output  1  an interrupt is presented to the processor.
REQ-016 irq_id  output  ID_W  index of the presented source.
REQ-017 irq_prio  output  PRIO_W  priority of the presented source.
REQ-018 irq_serviced  input  1  one-cycle pulse: processor finished servicing irq_id.

Function
REQ-019 Register map (word index): 0..NUM_SRC-1 PRIO[i] RW, bits [PRIO_W-1:0]; NUM_SRC ENABLE RW; +1 MODE RW (1=edge, 0=level); +2 PENDING RO, write-1-clears edge bits; +3 THRESHOLD RW [PRIO_W-1:0]; +4 STATUS RO {bit8 busy, [ID_W-1:0] current id}.
REQ-020 APB access phase = psel&penable; write takes effect at that edge; prdata updates at that edge; unused bits read 0.
REQ-021 Unmapped address: write ignored, prdata=0, pslverr=1 in that access phase only; pslverr=0 otherwise.
REQ-022 Edge pending[i] SHALL set when MODE[i]=1 and irq_src[i] rises (current 1, previous-cycle sample 0), regardless of ENABLE.
REQ-023 Edge pending[i] SHALL clear on irq_serviced with irq_id=i, or on PENDING write with bit i=1; a new rising edge in the same cycle wins (stays set).
REQ-024 Level source: PENDING[i] reads irq_src[i] directly; no latch.
REQ-025 Source i eligible when PENDING[i]=1, ENABLE[i]=1, PRIO[i]!=0, PRIO[i]>THRESHOLD.
REQ-026 Winner = highest PRIO among eligible; ties go to lowest index.
REQ-027 FSM states IDLE, ARB, SERVE; reset state IDLE.
REQ-028 IDLE: any eligible -> ARB; else stay.
REQ-029 ARB: winner exists -> register irq_id/irq_prio, irq_valid=1, -> SERVE; no eligible source -> IDLE, irq_valid stays 0.
REQ-030 SERVE: irq_id, irq_prio, irq_valid held stable irrespective of register writes or source deassertion; irq_serviced=1 -> irq_valid=0 next edge, -> IDLE.
REQ-031 Latency: eligible source at edge N seen in IDLE -> irq_valid=1 after edge N+2; minimum one IDLE cycle between consecutive presentations.
REQ-032 irq_serviced outside SERVE SHALL be ignored (no pending clear, no state change).
REQ-033 Simultaneous APB write to PRIO/ENABLE/THRESHOLD and ARB evaluation: ARB uses pre-write values.

Reset
REQ-034 On preset_n=0, asynchronously: all PRIO, ENABLE, MODE, THRESHOLD, edge pending and input-history flops = 0; state=IDLE; irq_valid=0, irq_id=0, irq_prio=0, prdata=0, pslverr=0.
REQ-035 Reset asserted mid-SERVE SHALL drop irq_valid immediately without waiting for a clock.
REQ-036 First rising edge after deassertion SHALL not detect an edge on a source already high at reset release.

Verification (NUM_SRC=8, PRIO_W=3)
REQ-037 PRIO[2]=5, PRIO[6]=3, ENABLE=0x44, level, irq_src=0x44 -> irq_valid=1, irq_id=2, irq_prio=5 two cycles later; serviced, src2 low -> next irq_id=6.
REQ-038 PRIO[1]=PRIO[4]=4, both enabled and active -> irq_id=1; THRESHOLD=4 -> nothing presented.
REQ-039 MODE[3]=1, one-cycle pulse on irq_src[3] while disabled, then ENABLE[3]=1 -> PENDING=0x08, presented id 3; after irq_serviced PENDING=0x00.
REQ-040 During SERVE id 2, write PRIO[2]=0 and drop irq_src[2] -> irq_id/irq_valid unchanged until irq_serviced.
REQ-041 Read paddr=NUM_SRC+7 -> prdata=0, pslverr=1; write there -> no register changes.
REQ-042 Assert preset_n=0 between clock edges during SERVE -> irq_valid=0 immediately; all registers read 0 after release.
